// File: rtl/wgt_buf_pkg.sv
// Purpose: shared defaults and helpers for the weight ping-pong buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wgt_buf_pkg;

    localparam int WGT_DW    = 8;
    localparam int WGT_DEPTH = 4;

    // Width of a counter that has to reach DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wgt_shift_bank.sv
// Purpose: shadow weight chain; each enabled cycle shifts lanes up by one and loads din into lane 0.
// Latency: 1 cycle from en to dout.
// Backpressure: none; the caller gates en.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all lanes)
//   en         : shift enable
//   din        : word entering lane 0
//   dout       : all lanes flattened, lane k at [k*DW +: DW]
module wgt_shift_bank
    import wgt_buf_pkg::*;
#(
    parameter int DW    = WGT_DW,
    parameter int DEPTH = WGT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DW-1:0]         din,
    output logic [DEPTH*DW-1:0]   dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (en) begin
            // Oldest word migrates toward lane DEPTH-1; the top lane drops off.
            dout <= {dout[(DEPTH-1)*DW-1:0], din};
        end
    end

endmodule

// File: rtl/wgt_pingpong_buf.sv
// Purpose: double-buffered weight store; a shadow bank loads serially while the active bank drives wgt_out.
// Latency: swap on a full shadow updates wgt_out 1 cycle later; a swap on a partial shadow waits for the last word.
// Backpressure: wgt_ready drops while stalled or while the shadow is full and waiting for a swap.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   stall                 : freeze all state
//   clear                 : discard shadow contents and any pending swap
//   wgt_in/valid/ready    : serial weight load handshake
//   swap                  : one-cycle request to move shadow into active
//   wgt_out               : active bank, lane k at [k*DW +: DW]
//   act_valid             : active bank has been loaded at least once
//   shadow_full           : shadow holds DEPTH words
//   swap_done             : pulses the cycle after a swap executes
module wgt_pingpong_buf
    import wgt_buf_pkg::*;
#(
    parameter int DW    = WGT_DW,
    parameter int DEPTH = WGT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  clear,
    input  logic [DW-1:0]         wgt_in,
    input  logic                  wgt_valid,
    output logic                  wgt_ready,
    input  logic                  swap,
    output logic [DEPTH*DW-1:0]   wgt_out,
    output logic                  act_valid,
    output logic                  shadow_full,
    output logic                  swap_done
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  swap_pend;
    logic                  accept;
    logic                  swap_exec;
    logic [DEPTH*DW-1:0]   shadow_flat;
    logic [DEPTH*DW-1:0]   active_q;

    // Depends only on registered state and stall, never on valid/swap/clear.
    assign wgt_ready = !stall && !shadow_full;
    assign accept    = wgt_valid && wgt_ready && !clear;
    // accept needs !shadow_full and swap_exec needs shadow_full, so they never coincide.
    assign swap_exec = (swap || swap_pend) && shadow_full && !stall && !clear;
    assign wgt_out   = active_q;

    wgt_shift_bank #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .din   (wgt_in),
        .dout  (shadow_flat)
    );

    always_comb begin
        cnt_nxt = cnt;
        if (clear || swap_exec) begin
            cnt_nxt = '0;
        end else if (accept) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            shadow_full <= 1'b0;
            swap_pend   <= 1'b0;
            active_q    <= '0;
            act_valid   <= 1'b0;
            swap_done   <= 1'b0;
        end else if (stall) begin
            // Everything holds except the done pulse, which must not stretch across a stall.
            swap_done <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            shadow_full <= (cnt_nxt == CNT_FULL);
            swap_done   <= swap_exec;
            if (clear || swap_exec) begin
                swap_pend <= 1'b0;
            end else if (swap) begin
                swap_pend <= 1'b1;
            end
            if (swap_exec) begin
                active_q  <= shadow_flat;
                act_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wgt_pingpong_buf.sv
// Purpose: self-checking bench for wgt_pingpong_buf (DW=8, DEPTH=4): directed table, reset corner, random vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wgt_pingpong_buf;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  stall;
    logic                  clear;
    logic [DW-1:0]         wgt_in;
    logic                  wgt_valid;
    logic                  wgt_ready;
    logic                  swap;
    logic [DEPTH*DW-1:0]   wgt_out;
    logic                  act_valid;
    logic                  shadow_full;
    logic                  swap_done;

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    wgt_pingpong_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .clear       (clear),
        .wgt_in      (wgt_in),
        .wgt_valid   (wgt_valid),
        .wgt_ready   (wgt_ready),
        .swap        (swap),
        .wgt_out     (wgt_out),
        .act_valid   (act_valid),
        .shadow_full (shadow_full),
        .swap_done   (swap_done)
    );

    typedef struct {
        logic        stall;
        logic        clear;
        logic        vld;
        logic [7:0]  din;
        logic        swap;
        logic        rdy;
        logic        full;
        logic        actv;
        logic        done;
        logic [31:0] out;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic st, logic cl, logic vl, logic [7:0] d, logic sw,
                               logic rd, logic fu, logic av, logic dn, logic [31:0] o);
        vec_t r;
        r.stall = st; r.clear = cl; r.vld = vl; r.din = d; r.swap = sw;
        r.rdy = rd; r.full = fu; r.actv = av; r.done = dn; r.out = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic cl, input logic vl, input logic [7:0] d, input logic sw);
        stall = st; clear = cl; wgt_valid = vl; wgt_in = d; swap = sw;
    endtask

    // Drive one cycle of inputs at the falling edge, check registered results just after the rising edge.
    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        drive(x.stall, x.clear, x.vld, x.din, x.swap);
        @(posedge clk);
        #1;
        chk({tag, " wgt_out"}, 64'(wgt_out), 64'(x.out));
        chk({tag, " rdy/full/actv/done"},
            64'({wgt_ready, shadow_full, act_valid, swap_done}),
            64'({x.rdy, x.full, x.actv, x.done}));
    endtask

    // Behavioural reference: shadow as a queue of words in arrival order.
    logic [7:0] mq[$];
    logic [7:0] mact[DEPTH];
    logic       mpend;
    logic       mactv;
    logic       mdone;

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < DEPTH; k++) mact[k] = 8'h00;
        mpend = 1'b0;
        mactv = 1'b0;
        mdone = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic cl, input logic vl, input logic [7:0] d, input logic sw);
        bit full;
        full  = (mq.size() == DEPTH);
        mdone = 1'b0;
        if (st) begin
            // frozen
        end else if (cl) begin
            mq.delete();
            mpend = 1'b0;
        end else if ((sw || mpend) && full) begin
            // First-loaded word ends up in the top lane.
            for (int k = 0; k < DEPTH; k++) mact[k] = mq[DEPTH-1-k];
            mq.delete();
            mpend = 1'b0;
            mactv = 1'b1;
            mdone = 1'b1;
        end else begin
            if (vl && !full) mq.push_back(d);
            if (sw) mpend = 1'b1;
        end
    endtask

    localparam logic [31:0] PA = 32'h01020304;
    localparam logic [31:0] PB = 32'h0B0CFB06;
    localparam logic [31:0] PC = 32'h1F202122;
    localparam logic [31:0] PD = 32'h0708090A;

    initial begin
        vec_t x;
        logic [31:0] exp_out;
        logic st, cl, vl, sw;
        logic [7:0] d;

        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset wgt_out", 64'(wgt_out), 64'h0);
        chk("reset rdy/full/actv/done",
            64'({wgt_ready, shadow_full, act_valid, swap_done}), 64'(4'b1000));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load and swap on a full shadow.
        vecs.push_back(v(0,0,1,8'd1,0, 1,0,0,0,32'h0));
        vecs.push_back(v(0,0,1,8'd2,0, 1,0,0,0,32'h0));
        vecs.push_back(v(0,0,1,8'd3,0, 1,0,0,0,32'h0));
        vecs.push_back(v(0,0,1,8'd4,0, 0,1,0,0,32'h0));
        vecs.push_back(v(0,0,0,8'd0,1, 1,0,1,1,PA));
        vecs.push_back(v(0,0,0,8'd0,0, 1,0,1,0,PA));
        // Swap requested after two words executes after the fourth without a new pulse.
        vecs.push_back(v(0,0,1,8'd11,0, 1,0,1,0,PA));
        vecs.push_back(v(0,0,1,8'd12,0, 1,0,1,0,PA));
        vecs.push_back(v(0,0,0,8'd0,1,  1,0,1,0,PA));
        vecs.push_back(v(0,0,1,8'hFB,0, 1,0,1,0,PA));
        vecs.push_back(v(0,0,1,8'd6,0,  0,1,1,0,PA));
        vecs.push_back(v(0,0,0,8'd0,0,  1,0,1,1,PB));
        vecs.push_back(v(0,0,0,8'd0,0,  1,0,1,0,PB));
        // Clear beats a simultaneous swap on a full shadow.
        vecs.push_back(v(0,0,1,8'd21,0, 1,0,1,0,PB));
        vecs.push_back(v(0,0,1,8'd22,0, 1,0,1,0,PB));
        vecs.push_back(v(0,0,1,8'd23,0, 1,0,1,0,PB));
        vecs.push_back(v(0,0,1,8'd24,0, 0,1,1,0,PB));
        vecs.push_back(v(0,1,0,8'd0,1,  1,0,1,0,PB));
        vecs.push_back(v(0,0,0,8'd0,0,  1,0,1,0,PB));
        // Full shadow refuses further words.
        vecs.push_back(v(0,0,1,8'd31,0, 1,0,1,0,PB));
        vecs.push_back(v(0,0,1,8'd32,0, 1,0,1,0,PB));
        vecs.push_back(v(0,0,1,8'd33,0, 1,0,1,0,PB));
        vecs.push_back(v(0,0,1,8'd34,0, 0,1,1,0,PB));
        vecs.push_back(v(0,0,1,8'd99,0, 0,1,1,0,PB));
        vecs.push_back(v(0,0,1,8'd99,0, 0,1,1,0,PB));
        vecs.push_back(v(0,0,1,8'd99,0, 0,1,1,0,PB));
        vecs.push_back(v(0,0,0,8'd0,1,  1,0,1,1,PC));
        // Stall mid-load with valid and swap asserted: nothing moves, swap not remembered.
        vecs.push_back(v(0,0,1,8'd7,0,  1,0,1,0,PC));
        vecs.push_back(v(0,0,1,8'd8,0,  1,0,1,0,PC));
        vecs.push_back(v(1,0,1,8'd9,1,  0,0,1,0,PC));
        vecs.push_back(v(1,0,1,8'd9,1,  0,0,1,0,PC));
        vecs.push_back(v(1,0,1,8'd9,1,  0,0,1,0,PC));
        vecs.push_back(v(0,0,1,8'd9,0,  1,0,1,0,PC));
        vecs.push_back(v(0,0,1,8'd10,0, 0,1,1,0,PC));
        vecs.push_back(v(0,0,0,8'd0,0,  0,1,1,0,PC));
        vecs.push_back(v(0,0,0,8'd0,1,  1,0,1,1,PD));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a load with a swap pending.
        apply(v(0,0,1,8'd41,0, 1,0,1,0,PD), "rst pre0");
        apply(v(0,0,1,8'd42,0, 1,0,1,0,PD), "rst pre1");
        apply(v(0,0,1,8'd43,0, 1,0,1,0,PD), "rst pre2");
        apply(v(0,0,0,8'd0,1,  1,0,1,0,PD), "rst pend");
        drive(0, 0, 0, 8'h00, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst wgt_out", 64'(wgt_out), 64'h0);
        chk("async rst rdy/full/actv/done",
            64'({wgt_ready, shadow_full, act_valid, swap_done}), 64'(4'b1000));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(v(0,0,1,8'd1,0, 1,0,0,0,32'h0), "post rst 1");
        apply(v(0,0,1,8'd2,0, 1,0,0,0,32'h0), "post rst 2");
        apply(v(0,0,1,8'd3,0, 1,0,0,0,32'h0), "post rst 3");
        apply(v(0,0,1,8'd4,0, 0,1,0,0,32'h0), "post rst 4");
        apply(v(0,0,0,8'd0,0, 0,1,0,0,32'h0), "post rst no pend");
        apply(v(0,0,0,8'd0,1, 1,0,1,1,PA),    "post rst swap");

        // Randomised traffic against the queue model, from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 19) == 0);
            vl = ($urandom_range(0, 9) < 7);
            sw = ($urandom_range(0, 6) == 0);
            d  = 8'($urandom);
            @(negedge clk);
            drive(st, cl, vl, d, sw);
            model_step(st, cl, vl, d, sw);
            @(posedge clk);
            #1;
            for (int k = 0; k < DEPTH; k++) exp_out[k*DW +: DW] = mact[k];
            chk($sformatf("rand%0d wgt_out", n), 64'(wgt_out), 64'(exp_out));
            chk($sformatf("rand%0d rdy/full/actv/done", n),
                64'({wgt_ready, shadow_full, act_valid, swap_done}),
                64'({!st && (mq.size() != DEPTH), mq.size() == DEPTH, mactv, mdone}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
